// File: rtl/fp16_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : fp16_pkg                                                         |
// | Purpose : Shared fp16 field widths, special encodings and the state type   |
// |           of the fixed-point to fp16 normaliser.                           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package fp16_pkg;

    localparam int FP16_EXP_W  = 5;
    localparam int FP16_MANT_W = 10;
    localparam int FP16_BIAS   = 15;

    localparam logic [15:0] FP16_POS_INF = 16'h7C00;
    localparam logic [15:0] FP16_ZERO    = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } state_t;

endpackage : fp16_pkg
`default_nettype wire

// File: rtl/fp16_round_pack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fp16_round_pack                                                  |
// | Purpose : Combinational round-to-nearest-even and pack of a left-normalised|
// |           magnitude into an fp16 word, with saturation to +/-inf and       |
// |           flush-to-zero (no subnormals).                                   |
// | Ports   : i_mag       normalised magnitude (MSB set unless zero)           |
// |           i_shift     number of left shifts applied during normalisation   |
// |           i_exp       shared input exponent                                |
// |           i_sign      result sign                                          |
// |           o_fp        packed fp16 {sign, exp, mant}                        |
// |           o_overflow  result saturated to +/-inf                           |
// |           o_underflow nonzero input flushed to +/-0                        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module fp16_round_pack
    import fp16_pkg::*;
#(
    parameter int ACC_WIDTH = 32,
    parameter int FRAC_BITS = 10,
    parameter int BIAS      = 15,
    parameter int SHIFT_W   = $clog2(ACC_WIDTH)
) (
    input  logic [ACC_WIDTH-1:0]  i_mag,
    input  logic [SHIFT_W-1:0]    i_shift,
    input  logic [FP16_EXP_W-1:0] i_exp,
    input  logic                  i_sign,
    output logic [15:0]           o_fp,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    // Exponent arithmetic is done signed and wide enough that neither the
    // largest input exponent nor the largest shift count can wrap.
    localparam int c_E_W = 12;
    // Unbiased exponent of the MSB of the input word, rebased to fp16 bias.
    localparam logic signed [c_E_W-1:0] c_EXP_OFS  = c_E_W'(ACC_WIDTH - 1 - FRAC_BITS - BIAS + FP16_BIAS);
    localparam logic signed [c_E_W-1:0] c_EXP_MAX  = c_E_W'((1 << FP16_EXP_W) - 1);
    localparam logic signed [c_E_W-1:0] c_EXP_ZERO = '0;
    // Bit position of the guard bit, directly below the kept mantissa field.
    localparam int c_G = ACC_WIDTH - 2 - FP16_MANT_W;

    logic [FP16_MANT_W-1:0]    w_mant;
    logic                      w_guard;
    logic                      w_sticky;
    logic                      w_round_up;
    logic [FP16_MANT_W:0]      w_mant_inc;
    logic signed [c_E_W-1:0]   w_exp_base;
    logic signed [c_E_W-1:0]   w_exp_rnd;

    // The MSB of i_mag is the implicit leading one and is not stored.
    assign w_mant     = i_mag[ACC_WIDTH-2 -: FP16_MANT_W];
    assign w_guard    = i_mag[c_G];
    assign w_sticky   = |i_mag[c_G-1:0];
    assign w_round_up = w_guard & (w_sticky | w_mant[0]);
    assign w_mant_inc = {1'b0, w_mant} + {{FP16_MANT_W{1'b0}}, w_round_up};

    assign w_exp_base = $signed({{(c_E_W-FP16_EXP_W){1'b0}}, i_exp}) + c_EXP_OFS
                      - $signed({{(c_E_W-SHIFT_W){1'b0}}, i_shift});
    // A mantissa carry-out leaves the low field at zero and bumps the exponent.
    assign w_exp_rnd  = w_exp_base + $signed({{(c_E_W-1){1'b0}}, w_mant_inc[FP16_MANT_W]});

    always_comb begin
        o_fp        = FP16_ZERO;
        o_overflow  = 1'b0;
        o_underflow = 1'b0;
        if (i_mag != '0) begin
            if (w_exp_rnd >= c_EXP_MAX) begin
                o_fp       = {i_sign, FP16_POS_INF[14:0]};
                o_overflow = 1'b1;
            end else if (w_exp_rnd <= c_EXP_ZERO) begin
                o_fp        = {i_sign, FP16_ZERO[14:0]};
                o_underflow = 1'b1;
            end else begin
                o_fp = {i_sign, w_exp_rnd[FP16_EXP_W-1:0], w_mant_inc[FP16_MANT_W-1:0]};
            end
        end
    end

endmodule : fp16_round_pack
`default_nettype wire

// File: rtl/fixed_to_fp16_norm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fixed_to_fp16_norm                                               |
// | Purpose : Converts a signed fixed-point accumulator value with a shared    |
// |           5-bit exponent into an fp16 word. Normalisation shifts one bit   |
// |           per cycle; both sides use a valid/ready handshake.               |
// | Ports   : clk            clock, rising edge                                |
// |           rst            asynchronous reset, active low                    |
// |           in_valid       input word valid                                  |
// |           in_ready       ready to accept (only while idle)                 |
// |           fixed_point_in two's-complement accumulator value                |
// |           exp_in         shared exponent of fixed_point_in                 |
// |           out_valid      fp_out and flags valid                            |
// |           out_ready      consumer accepts the result                       |
// |           fp_out         fp16 result {sign, exp, mant}                     |
// |           overflow       result saturated to +/-inf                        |
// |           underflow      nonzero input flushed to +/-0                     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module fixed_to_fp16_norm
    import fp16_pkg::*;
#(
    parameter int ACC_WIDTH = 32,
    parameter int FRAC_BITS = 10,
    parameter int BIAS      = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ACC_WIDTH-1:0]  fixed_point_in,
    input  logic [FP16_EXP_W-1:0] exp_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           fp_out,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int c_SHIFT_W = $clog2(ACC_WIDTH);
    localparam logic [ACC_WIDTH-1:0] c_ONE       = {{(ACC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [c_SHIFT_W-1:0] c_SHIFT_ONE = {{(c_SHIFT_W-1){1'b0}}, 1'b1};

    state_t                  r_state;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic                    r_sign;
    logic [ACC_WIDTH-1:0]    r_mag;
    logic [FP16_EXP_W-1:0]   r_exp;
    logic [c_SHIFT_W-1:0]    r_shift;
    logic [15:0]             r_fp_out;
    logic                    r_overflow;
    logic                    r_underflow;

    logic                    w_sign_in;
    logic [ACC_WIDTH-1:0]    w_mag_in;
    logic [15:0]             w_fp;
    logic                    w_overflow;
    logic                    w_underflow;

    // The most negative input has no positive counterpart in ACC_WIDTH signed
    // bits, but its unsigned magnitude (only MSB set) is exactly right.
    assign w_sign_in = fixed_point_in[ACC_WIDTH-1];
    assign w_mag_in  = w_sign_in ? (~fixed_point_in + c_ONE) : fixed_point_in;

    fp16_round_pack #(
        .ACC_WIDTH (ACC_WIDTH),
        .FRAC_BITS (FRAC_BITS),
        .BIAS      (BIAS),
        .SHIFT_W   (c_SHIFT_W)
    ) u_round_pack (
        .i_mag       (r_mag),
        .i_shift     (r_shift),
        .i_exp       (r_exp),
        .i_sign      (r_sign),
        .o_fp        (w_fp),
        .o_overflow  (w_overflow),
        .o_underflow (w_underflow)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_sign      <= 1'b0;
            r_mag       <= '0;
            r_exp       <= '0;
            r_shift     <= '0;
            r_fp_out    <= FP16_ZERO;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sign     <= w_sign_in;
                        r_mag      <= w_mag_in;
                        r_exp      <= exp_in;
                        r_shift    <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= NORM;
                    end
                end
                NORM: begin
                    // A zero magnitude never normalises; it leaves with s=0.
                    if (r_mag[ACC_WIDTH-1] || (r_mag == '0)) begin
                        r_state <= ROUND;
                    end else begin
                        r_mag   <= {r_mag[ACC_WIDTH-2:0], 1'b0};
                        r_shift <= r_shift + c_SHIFT_ONE;
                    end
                end
                ROUND: begin
                    r_fp_out    <= w_fp;
                    r_overflow  <= w_overflow;
                    r_underflow <= w_underflow;
                    r_out_valid <= 1'b1;
                    r_state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign fp_out    = r_fp_out;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule : fixed_to_fp16_norm
`default_nettype wire
